// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV64M multiply/divide unit. It accepts one operation through a
// valid/ready handshake and resolves one operand bit per cycle:
//    - multiply uses shift-add
//    - divide uses restoring division
// The result is returned through a second valid/ready handshake.
// Divide-by-zero and signed-division overflow finish immediately with the
// architecturally defined results.
//
// Ports:
//    clk          clock, rising edge
//    rst_n        synchronous active-low reset
//    in_valid     request present
//    in_ready     unit idle and able to accept a request
//    input_a      multiplicand / dividend
//    input_b      multiplier / divisor
//    operation    M-extension funct3 (MUL..REMU)
//    out_valid    result present
//    out_ready    consumer takes the result
//    result       operation result
//    overflow     signed DIV/REM of most-negative by -1
//    div_by_zero  DIV/DIVU/REM/REMU with a zero divisor
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WORDSIZE = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORDSIZE-1:0] input_a,
   input  logic [WORDSIZE-1:0] input_b,
   input  logic [2:0]          operation,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORDSIZE-1:0] result,
   output logic                overflow,
   output logic                div_by_zero
);

   localparam int CW = $clog2(WORDSIZE);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [CW-1:0]       r_count;
   logic [2:0]          r_op;
   logic [WORDSIZE-1:0] r_opnd;
   logic [WORDSIZE-1:0] r_hi;
   logic [WORDSIZE-1:0] r_lo;
   logic                r_negQ;
   logic                r_negR;
   logic [WORDSIZE-1:0] r_result;
   logic                r_overflow;
   logic                r_divByZero;

   logic                w_signA;
   logic                w_signB;
   logic [WORDSIZE-1:0] w_magA;
   logic [WORDSIZE-1:0] w_magB;
   logic                w_divZero;
   logic                w_signedOvf;
   logic [WORDSIZE:0]   w_sum;
   logic [WORDSIZE:0]   w_shift;
   logic                w_fits;
   logic [WORDSIZE-1:0] w_trialLow;
   logic [WORDSIZE-1:0] w_nextHi;
   logic [WORDSIZE-1:0] w_nextLo;
   logic [2*WORDSIZE-1:0] w_prod;
   logic [2*WORDSIZE-1:0] w_prodSigned;
   logic [WORDSIZE-1:0] w_quo;
   logic [WORDSIZE-1:0] w_rem;
   logic [WORDSIZE-1:0] w_final;

   // Decode the signedness of each operand from funct3.
   // For divides, op[0]=0 selects signed DIV/REM.
   // For multiplies:
   //    - a is signed unless MULHU
   //    - b is signed only for MUL/MULH
   // The datapath then works purely on magnitudes.
   always_comb begin
      w_signA     = 1'b0;
      w_signB     = 1'b0;
      if (operation[2]) begin
         w_signA = input_a[WORDSIZE-1] & ~operation[0];
         w_signB = input_b[WORDSIZE-1] & ~operation[0];
      end else begin
         w_signA = input_a[WORDSIZE-1] & (operation[1:0] != 2'b11);
         w_signB = input_b[WORDSIZE-1] & ~operation[1];
      end
      w_magA      = w_signA ? -input_a : input_a;
      w_magB      = w_signB ? -input_b : input_b;
      w_divZero   = operation[2] & (input_b == '0);
      w_signedOvf = operation[2] & ~operation[0]
                    & (input_a == {1'b1, {(WORDSIZE-1){1'b0}}})
                    & (input_b == '1);
   end

   // One iteration of the datapath. r_hi/r_lo form a double-width working
   // register shared by both algorithms.
   //
   // Multiply:
   //    - r_lo holds the remaining multiplier bits
   //    - r_opnd is the multiplicand
   //    - the product assembles into {r_hi, r_lo} as it shifts right
   //
   // Divide:
   //    - r_lo shifts the dividend out MSB-first and collects quotient bits
   //    - r_hi is the partial remainder
   //    - r_opnd is the divisor
   //    - the trial subtraction is only taken in the low word, because a
   //      successful subtraction is always smaller than the divisor
   always_comb begin
      w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
      w_shift    = {r_hi, r_lo[WORDSIZE-1]};
      w_fits     = (w_shift >= {1'b0, r_opnd});
      w_trialLow = w_shift[WORDSIZE-1:0] - r_opnd;
      if (r_op[2]) begin
         w_nextHi = w_fits ? w_trialLow : w_shift[WORDSIZE-1:0];
         w_nextLo = {r_lo[WORDSIZE-2:0], w_fits};
      end else begin
         w_nextHi = w_sum[WORDSIZE:1];
         w_nextLo = {w_sum[0], r_lo[WORDSIZE-1:1]};
      end
   end

   // Sign correction applied to the last iteration's output, so the result
   // register is loaded on the same edge that enters DONE.
   //
   // Sign rules:
   //    - product and quotient are negative when the operand signs differ
   //    - the remainder follows the dividend's sign
   always_comb begin
      w_prod       = {w_nextHi, w_nextLo};
      w_prodSigned = r_negQ ? -w_prod : w_prod;
      w_quo        = r_negQ ? -w_nextLo : w_nextLo;
      w_rem        = r_negR ? -w_nextHi : w_nextHi;
      w_final      = '0;
      case (r_op)
         3'b000:         w_final = w_prodSigned[WORDSIZE-1:0];
         3'b100, 3'b101: w_final = w_quo;
         3'b110, 3'b111: w_final = w_rem;
         default:        w_final = w_prodSigned[2*WORDSIZE-1:WORDSIZE];
      endcase
   end

   // Next-state logic.
   // Special cases skip BUSY entirely. BUSY runs exactly WORDSIZE iterations.
   // DONE waits for the consumer.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid)
                     w_nextState = (w_divZero | w_signedOvf) ? DONE : BUSY;
         BUSY:    if (r_count == CW'(WORDSIZE-1))
                     w_nextState = DONE;
         DONE:    if (out_ready)
                     w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // State register and datapath registers.
   // Operands are captured only on the accept edge, so later input changes
   // are invisible. The result and flags are written only on entry to DONE,
   // which keeps them stable under backpressure.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_op        <= '0;
         r_opnd      <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_negQ      <= 1'b0;
         r_negR      <= 1'b0;
         r_result    <= '0;
         r_overflow  <= 1'b0;
         r_divByZero <= 1'b0;
      end else begin
         r_state <= w_nextState;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_op        <= operation;
                  r_count     <= '0;
                  r_hi        <= '0;
                  r_negQ      <= w_signA ^ w_signB;
                  r_negR      <= w_signA;
                  r_overflow  <= w_signedOvf;
                  r_divByZero <= w_divZero;
                  if (operation[2]) begin
                     r_opnd <= w_magB;
                     r_lo   <= w_magA;
                  end else begin
                     r_opnd <= w_magA;
                     r_lo   <= w_magB;
                  end
                  if (w_divZero)
                     r_result <= operation[1] ? input_a : '1;
                  else if (w_signedOvf)
                     r_result <= operation[1] ? '0 : input_a;
               end
            end
            BUSY: begin
               r_hi    <= w_nextHi;
               r_lo    <= w_nextLo;
               r_count <= r_count + CW'(1);
               if (r_count == CW'(WORDSIZE-1))
                  r_result <= w_final;
            end
            default: ;
         endcase
      end
   end

   // Handshake outputs.
   // in_ready is masked by rst_n so it stays low through the reset cycle.
   always_comb begin
      in_ready    = (r_state == IDLE) & rst_n;
      out_valid   = (r_state == DONE);
      result      = r_result;
      overflow    = r_overflow;
      div_by_zero = r_divByZero;
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit at WORDSIZE=64. It covers:
//    - arithmetic vectors, with expected values worked out by hand
//    - special-case flags
//    - latencies
//    - backpressure and operand-hold behaviour
//    - reset in the middle of an operation
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] input_a;
   logic [63:0] input_b;
   logic [2:0]  operation;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        overflow;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;
   int lat;
   logic [63:0] saved;

   localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                          OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                          OP_REM = 3'b110, OP_REMU = 3'b111;

   muldiv_unit #(.WORDSIZE(64)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .input_a(input_a),
      .input_b(input_b),
      .operation(operation),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .overflow(overflow),
      .div_by_zero(div_by_zero)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and reports observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present a request and hold it until the accept edge, then drop in_valid.
   // Returns 1 time unit after the accept edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a,
                                input logic [63:0] b);
      int n;
      n = 0;
      operation = op;
      input_a   = a;
      input_b   = b;
      in_valid  = 1'b1;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges from the accept edge (counted as 1) until out_valid is seen.
   task automatic waitOutput(output int latency);
      latency = 1;
      while (!out_valid && latency < 300) begin
         @(posedge clk); #1;
         latency++;
      end
      checkOutput("outValid", 64'(out_valid), 64'd1);
   endtask

   // Complete the output handshake; in_ready must be back right after it.
   task automatic takeOutput();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("inReadyAfterHandshake", 64'(in_ready), 64'd1);
   endtask

   // Full transaction with result, flag and latency checks.
   task automatic runOp(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] expRes,
                        input logic expOvf, input logic expDbz, input int expLat);
      int l;
      applyStimulus(op, a, b);
      waitOutput(l);
      checkOutput({tag, ".result"}, result, expRes);
      checkOutput({tag, ".overflow"}, 64'(overflow), 64'(expOvf));
      checkOutput({tag, ".divByZero"}, 64'(div_by_zero), 64'(expDbz));
      checkOutput({tag, ".latency"}, 64'(l), 64'(expLat));
      takeOutput();
   endtask

   // Linear directed sequence.
   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      operation = 3'b000;
      input_a   = '0;
      input_b   = '0;

      // Reset values
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rst.inReady", 64'(in_ready), 64'd0);
      checkOutput("rst.outValid", 64'(out_valid), 64'd0);
      checkOutput("rst.result", result, 64'd0);
      checkOutput("rst.flags", 64'({overflow, div_by_zero}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst.inReadyAfter", 64'(in_ready), 64'd1);

      // Multiplies
      runOp("mulSigned", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
            64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0, 65);
      runOp("mulhu", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 65);
      runOp("mulh", OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h0, 1'b0, 1'b0, 65);
      runOp("mulhsu", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 65);

      // Divides
      runOp("divSigned", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 65);
      runOp("remSigned", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 65);
      runOp("divu", OP_DIVU, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 65);
      runOp("remu", OP_REMU, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0, 65);

      // Special cases
      runOp("divuByZero", OP_DIVU, 64'h1234, 64'd0,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1);
      runOp("remByZero", OP_REM, 64'h1234, 64'd0, 64'h1234, 1'b0, 1'b1, 1);
      runOp("divOverflow", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1'b1, 1'b0, 1);
      runOp("remOverflow", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h0, 1'b1, 1'b0, 1);

      // Operands and in_valid disturbed during BUSY, then backpressure
      applyStimulus(OP_DIVU, 64'd1000, 64'd10);
      repeat (5) begin
         @(posedge clk); #1;
      end
      input_a   = 64'hDEAD_BEEF;
      input_b   = 64'd3;
      operation = OP_MUL;
      in_valid  = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      waitOutput(lat);
      checkOutput("holdOperands.result", result, 64'd100);
      saved = result;
      repeat (10) begin
         @(posedge clk); #1;
         checkOutput("backpressure.result", result, saved);
         checkOutput("backpressure.inReady", 64'(in_ready), 64'd0);
         checkOutput("backpressure.outValid", 64'(out_valid), 64'd1);
      end
      takeOutput();

      // Reset at iteration 30 of a DIV, then a clean MUL
      applyStimulus(OP_DIV, 64'd1000, 64'd3);
      repeat (30) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("midReset.outValid", 64'(out_valid), 64'd0);
      checkOutput("midReset.result", result, 64'd0);
      checkOutput("midReset.flags", 64'({overflow, div_by_zero}), 64'd0);
      #1;
      checkOutput("midReset.inReady", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      checkOutput("midReset.outValidLater", 64'(out_valid), 64'd0);
      runOp("mulAfterReset", OP_MUL, 64'd6, 64'd7, 64'd42, 1'b0, 1'b0, 65);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the RV64M extension: the multi-cycle companion to the single-cycle `alu` in the execute stage. It accepts one operation through a valid/ready handshake and computes it one bit per cycle (shift-add multiply, restoring divide). It returns the result through a second valid/ready handshake, and flags divide-by-zero and signed-division overflow. The word width is parametrised, and `operation` uses the RISC-V M-extension funct3 encoding.

## Interface
- `WORDSIZE`, 64: operand and result width in bits; any value ≥ 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request (high only in IDLE).
- `input_a`  in  WORDSIZE  multiplicand or dividend.
- `input_b`  in  WORDSIZE  multiplier or divisor.
- `operation`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WORDSIZE  operation result.
- `overflow`  out  1  set for signed DIV/REM with input_a = most-negative and input_b = −1.
- `div_by_zero`  out  1  set for DIV/DIVU/REM/REMU with input_b = 0.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE:** `in_ready`=1. On `in_valid`: latch the operands and the operation, and clear both flags.
  - Special cases go directly to DONE: divide by zero, and signed overflow.
  - All other operations go to BUSY with the iteration counter at 0.
- **BUSY:** performs one iteration per cycle.
  - Counter runs 0..WORDSIZE−1.
  - After the iteration at count WORDSIZE−1, go to DONE with the sign-corrected result registered.
- **DONE:** `out_valid`=1. `result` and the flags are held stable until `out_ready`=1, then go to IDLE.
- Multiply:
  - Operands are converted to magnitudes per their signedness: MUL/MULH signed×signed, MULHSU signed a × unsigned b, MULHU unsigned×unsigned.
  - The 2·WORDSIZE-bit product is accumulated, then negated if the signs differ.
  - MUL returns bits [WORDSIZE−1:0]; the MULH variants return bits [2·WORDSIZE−1:WORDSIZE].
- Divide:
  - DIV/REM use magnitudes. The quotient is negated if the operand signs differ. The remainder takes the sign of the dividend.
  - DIVU/REMU are unsigned.
- Special-case results:
  - Divide by zero: quotient = all ones, remainder = input_a, `div_by_zero`=1.
  - Signed overflow: quotient = input_a (most-negative), remainder = 0, `overflow`=1.
- `overflow` and `div_by_zero` are always 0 for multiply operations.

## Timing
- Reset values (`rst_n`=0 at an edge):
  - State IDLE; `out_valid`=0, `result`=0, `overflow`=0, `div_by_zero`=0, counter 0.
  - `in_ready` is 0 during the reset cycle and 1 from the first cycle after reset deasserts.
- Acceptance occurs on the edge where `in_valid` & `in_ready`.
- Normal latency: `out_valid` rises WORDSIZE+1 edges after the accept edge (65 for WORDSIZE=64).
- Special-case latency: `out_valid` rises 1 edge after the accept edge.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `result` and the flags must not change.
- Handshake turnaround:
  - Output handshake on edge E → `in_ready`=1 after E.
  - A new request can be accepted at the earliest on E+1. There is no back-to-back overlap.
- Operand hold: `input_a`, `input_b` and `operation` need only be valid on the accept edge. Later changes have no effect.
- Other edges:
  - `in_valid` while BUSY/DONE is ignored and not latched.
  - `out_ready` while not in DONE has no effect.
- Reset mid-operation: `rst_n`=0 in BUSY or DONE aborts the operation. The pending result is discarded, and outputs take the reset values on that edge.

## Test plan
(WORDSIZE=64.)
- **MUL signed:** MUL 3 × 0xFFFF_FFFF_FFFF_FFFB (−5) → result 0xFFFF_FFFF_FFFF_FFF1, flags 0. `out_valid` exactly 65 cycles after the accept edge.
- **MULHU / MULH:**
  - MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE.
  - MULH with the same operands (−1 × −1) → 0x0000_0000_0000_0000.
- **Signed divide:**
  - DIV −7 ÷ 2 → 0xFFFF_FFFF_FFFF_FFFD.
  - REM −7 ÷ 2 → 0xFFFF_FFFF_FFFF_FFFF.
  - DIVU 100 ÷ 7 → 14.
  - REMU 100 ÷ 7 → 2.
- **Special cases:**
  - DIVU 0x1234 ÷ 0 → result all ones, `div_by_zero`=1, `out_valid` 1 cycle after accept.
  - REM 0x1234 ÷ 0 → 0x1234.
  - DIV 0x8000_0000_0000_0000 ÷ −1 → 0x8000_0000_0000_0000, `overflow`=1.
  - REM with the same operands → 0, `overflow`=1.
- **Backpressure and stability:**
  - `out_ready` held 0 for 10 cycles after `out_valid` → `result` stable and `in_ready`=0 throughout.
  - Operands changed during BUSY and `in_valid` pulsed → result unaffected.
  - After the output handshake, `in_ready`=1 on the next cycle.
- **Reset mid-operation:** `rst_n`=0 for one cycle at iteration 30 of a DIV → all outputs 0 and `in_ready`=1 afterwards. A following MUL 6 × 7 returns 42 with normal latency.
